// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: icode values, fetch FSM states, datapath widths.
package y86_pkg;

    localparam int unsigned PC_W  = 64;
    localparam int unsigned WIN_W = 80;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        S_FETCH0,
        S_FETCHN,
        S_HOLD,
        S_STOP
    } fetch_state_e;

endpackage

// File: rtl/ilen_decode.sv
// Combinational icode decode: instruction length and field presence.
module ilen_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] length,
    output logic       instr_valid,
    output logic       need_regids,
    output logic       need_valC
);

    // Length and field flags per icode; illegal codes fall back to one byte.
    always_comb begin
        length      = 4'd1;
        instr_valid = 1'b1;
        need_regids = 1'b0;
        need_valC   = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: length = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                length      = 4'd2;
                need_regids = 1'b1;
            end
            I_JXX, I_CALL: begin
                length    = 4'd9;
                need_valC = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                length      = 4'd10;
                need_regids = 1'b1;
                need_valC   = 1'b1;
            end
            default: instr_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_assembler.sv
// Byte-serial Y86-64 instruction fetcher: collects one instruction into an
// 80-bit little-endian window and presents it with valP via valid/ready.
// Optional: FETCH_HALT_STOP_EN stops fetching after an accepted halt.
module fetch_assembler
    import y86_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             pc_load,
    output logic [PC_W-1:0]  mem_addr,
    output logic             mem_req,
    input  logic             mem_ack,
    input  logic [7:0]       mem_rdata,
    input  logic             mem_err,
    output logic [WIN_W-1:0] ibytes,
    output logic             ibytes_valid,
    input  logic             ibytes_ready,
    output logic [PC_W-1:0]  valP,
    output logic             instr_valid,
    output logic             imem_error
);

    fetch_state_e     state_q;
    logic [PC_W-1:0]  pc_q;
    logic [3:0]       cnt_q;
    logic [3:0]       len_q;
    logic [WIN_W-1:0] ibytes_q;
    logic [PC_W-1:0]  valp_q;
    logic             ivalid_q;
    logic             ierr_q;

    logic [3:0]       dec_len;
    logic             dec_valid;
    logic             dec_regids;
    logic             dec_valc;
    logic             unused_dec;
    logic [WIN_W-1:0] win_d;
    logic             stop_d;

    ilen_decode u_ilen_decode (
        .icode       (mem_rdata[7:4]),
        .length      (dec_len),
        .instr_valid (dec_valid),
        .need_regids (dec_regids),
        .need_valC   (dec_valc)
    );

    assign unused_dec = dec_regids ^ dec_valc;

    // Window with the current byte merged at slot cnt; an errored byte lands as 00.
    always_comb begin
        win_d = ibytes_q;
        for (int unsigned k = 0; k < 10; k++) begin
            if (cnt_q == k[3:0]) begin
                win_d[8*k +: 8] = mem_err ? 8'h00 : mem_rdata;
            end
        end
    end

    // Conditions that park the fetcher in STOP once the window is accepted.
    always_comb begin
`ifdef FETCH_HALT_STOP_EN
        stop_d = ierr_q | (ibytes_q[7:4] == I_HALT);
`else
        stop_d = ierr_q;
`endif
    end

    // Fetch FSM: byte 0 decode, remaining bytes, hold for handshake, stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH0;
            pc_q     <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            ibytes_q <= '0;
            valp_q   <= '0;
            ivalid_q <= 1'b0;
            ierr_q   <= 1'b0;
        end else if (pc_load) begin
            state_q  <= S_FETCH0;
            pc_q     <= pc_in;
            cnt_q    <= '0;
            ibytes_q <= '0;
            valp_q   <= '0;
            ivalid_q <= 1'b0;
            ierr_q   <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH0: begin
                    if (mem_ack) begin
                        cnt_q <= 4'd1;
                        len_q <= dec_len;
                        if (mem_err) begin
                            ibytes_q <= '0;
                            valp_q   <= pc_q + 64'd1;
                            ivalid_q <= 1'b0;
                            ierr_q   <= 1'b1;
                            state_q  <= S_HOLD;
                        end else begin
                            ibytes_q <= {{(WIN_W-8){1'b0}}, mem_rdata};
                            valp_q   <= pc_q + {{(PC_W-4){1'b0}}, dec_len};
                            ivalid_q <= dec_valid;
                            ierr_q   <= 1'b0;
                            state_q  <= (dec_len == 4'd1) ? S_HOLD : S_FETCHN;
                        end
                    end
                end
                S_FETCHN: begin
                    if (mem_ack) begin
                        ibytes_q <= win_d;
                        cnt_q    <= cnt_q + 4'd1;
                        if (mem_err) begin
                            valp_q   <= pc_q + 64'd1;
                            ivalid_q <= 1'b0;
                            ierr_q   <= 1'b1;
                            state_q  <= S_HOLD;
                        end else if (cnt_q == len_q - 4'd1) begin
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (ibytes_ready) begin
                        if (stop_d) begin
                            state_q <= S_STOP;
                        end else begin
                            state_q <= S_FETCH0;
                            pc_q    <= valp_q;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_STOP: state_q <= S_STOP;
                default: state_q <= S_FETCH0;
            endcase
        end
    end

    // Request is gated by reset so it is low during reset and high the first cycle after.
    assign mem_req      = ~reset & ((state_q == S_FETCH0) | (state_q == S_FETCHN));
    assign mem_addr     = pc_q + {{(PC_W-4){1'b0}}, cnt_q};
    assign ibytes       = ibytes_q;
    assign ibytes_valid = (state_q == S_HOLD);
    assign valP         = valp_q;
    assign instr_valid  = ivalid_q;
    assign imem_error   = ierr_q;

endmodule

// File: doc/fetch_assembler.md
# fetch_assembler

Sequential instruction-byte fetcher at the head of the Y86-64 fetch stage. It reads the byte-wide instruction memory at the current PC through a req/ack handshake and decodes icode from byte 0 to get the instruction length. It then collects exactly that many bytes into an 80-bit little-endian window and hands the window, with valP, to the split/align logic through a valid/ready handshake.

## Interface
- No parameters; widths fixed by Y86-64 (64-bit PC, max 10-byte instruction).
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- pc_in  in  64  redirect target
- pc_load  in  1  redirect strobe
- mem_addr  out  64  byte address
- mem_req  out  1  read request
- mem_ack  in  1  read complete; may be combinational (same cycle as req)
- mem_rdata  in  8  read byte, valid when mem_ack
- mem_err  in  1  address error, sampled with mem_ack
- ibytes  out  80  byte k at [8k+7:8k]; byte 0 = {icode,ifun}; unused bytes zero
- ibytes_valid  out  1  window complete
- ibytes_ready  in  1  downstream accepts
- valP  out  64  PC + length
- instr_valid  out  1  icode legal (0x0–0xB)
- imem_error  out  1  memory error during this instruction

## Operation
- Lengths by icode: 0,1,9 → 1; 2,6,A,B → 2; 7,8 → 9; 3,4,5 → 10. Illegal icode (0xC–0xF) → 1, instr_valid=0.
- States:
  - FETCH0: request byte 0.
  - FETCHN: request bytes 1..L-1; byte counter cnt 4 bits.
  - HOLD: window presented.
  - STOP: idle until pc_load.
- FETCH0 → FETCHN on ack when L>1. FETCH0 → HOLD on ack when L=1.
- FETCHN → HOLD on the ack of byte L-1.
- HOLD → FETCH0 on valid&ready, with pc = valP.
- HOLD → STOP on valid&ready when imem_error=1. The macro adds a second STOP condition (see Configuration).
- mem_addr = pc + cnt (64-bit, wraps modulo 2^64). mem_req is held with a stable address until ack.
- mem_err on any byte: that byte is stored as 00, assembly ends immediately, the window is presented with imem_error=1, instr_valid=0, and valP = pc + 1.
- pc_load:
  - Priority below reset, above everything else.
  - Aborts the fetch in progress and discards collected bytes.
  - Drops ibytes_valid and forces FETCH0 at pc_in next cycle.
  - An ack arriving in the same cycle is ignored.
- Reset: pc=0, state FETCH0, all outputs 0; mem_req asserts in the first cycle after reset deasserts.

## Timing
- Byte k is captured on the clock edge where mem_req&mem_ack; at most one byte per cycle.
- ibytes_valid rises the cycle after the last-byte ack. With a zero-wait memory, a length-L instruction is valid L cycles after its first mem_req.
- In HOLD, ibytes/valP/flags are stable and mem_req=0 until the handshake. The next mem_req follows in the cycle after valid&ready.
- No prefetch: the next instruction is not fetched while HOLD persists.

## Configuration
- FETCH_HALT_STOP_EN defined:
  - After a halt (icode 0) is accepted, go to STOP.
  - mem_req stays 0 until pc_load.
- Undefined: halt is treated like any 1-byte instruction, and fetching continues at valP.

## Structure
- Shared package y86_pkg holds:
  - icode constants (I_HALT…I_POPQ).
  - fetch state enum.
  - Width constants: PC width 64, window 80.
- Sub-module ilen_decode (combinational): icode → length[3:0], instr_valid, need_regids, need_valC. The same decode is reusable by split/align.

## Test plan
- irmovq at pc 0, bytes 30 f8 08 00 00 00 00 00 00 00, ack every cycle → ibytes=80'h0000000000000008f830, valP=10, instr_valid=1, valid at cycle 10.
- nop (10) at 0x10 then ret (90) at 0x11 with ready=1 → two windows: 80'h10 with valP=0x11, then 80'h90 with valP=0x12.
- ibytes_ready low for 3 cycles in HOLD → window stable, mem_req=0; fetch resumes the cycle after ready.
- pc_load with pc_in=0x40 during byte 5 of a call → valid never asserts for the call; the next mem_addr is 0x40.
- mem_err on byte 2 of rmmovq at 0x20 → imem_error=1, valP=0x21, then STOP until pc_load.
- Byte 0 = 00 (halt) with FETCH_HALT_STOP_EN → no mem_req after acceptance. Without the macro → fetch at pc+1. Separately, byte 0 = C0 → length 1, instr_valid=0.
